koopa_palette_lut: RTL and testbench
====================================

# koopa_palette_lut

Eight-entry colour palette for the Koopa sprite: converts a 3-bit pixel index from a sprite ROM into a 6-bit RRGGBB colour plus a transparency flag. It sits between a sprite ROM and the pixel compositor and is read combinationally, so its output lands in the same cycle as the ROM data. The palette is writable at run time for recolouring, and a flash input supports hit effects.

## Interface
- No parameters. Palette depth is fixed at 8 entries and colour width at 6 bits.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; restores the default palette.
- index  in  3  pixel index from the sprite ROM.
- rgb  out  6  colour as {R[1:0],G[1:0],B[1:0]}; combinational from index.
- transparent  out  1  high when index==0; combinational.
- flash  in  1  when high, every opaque pixel outputs 6'h3F (white).
- wr_en  in  1  palette write strobe.
- wr_index  in  3  entry to overwrite.
- wr_rgb  in  6  new colour for that entry.

## Operation
- Storage is 8 × 6-bit registers, pal[0..7].
- Default contents, loaded on reset:
  - 0: 00 (transparent key)
  - 1: 00 (black outline)
  - 2: 0C (green)
  - 3: 04 (dark green)
  - 4: 3C (yellow)
  - 5: 3F (white)
  - 6: 30 (red)
  - 7: 38 (orange)
- Read path is purely combinational:
  - transparent = (index==0).
  - If transparent, rgb = pal[0] regardless of flash.
  - Else if flash, rgb = 6'h3F.
  - Else rgb = pal[index].
- Write path: on a rising edge with wr_en=1 and reset=0, pal[wr_index] <= wr_rgb. All other entries hold.
- Entry 0 is writable, and its stored value drives rgb for index 0. transparent depends only on index, never on pal[0].
- No X is allowed on rgb for any index value once reset has been applied.

## Timing
- Read latency is 0 cycles: rgb and transparent follow index and flash within the same cycle, with no register on the output.
- A write becomes visible on rgb from the cycle after the edge that captures it.
- Read and write to the same entry in the same cycle: rgb shows the old value in that cycle and the new value afterwards. There is no bypass.
- Reset and wr_en asserted together: reset wins, all entries return to defaults and the write is dropped.
- Reset mid-operation: defaults are visible the cycle after the reset edge. The read path keeps working combinationally while reset is high, showing current register contents until the edge.
- Back-to-back writes on consecutive cycles each take effect. If consecutive writes target the same entry, the last write wins.

## Test plan
- Reset, then sweep index 0..7 with flash=0 -> rgb = 00,00,0C,04,3C,3F,30,38 and transparent = 1 only at index 0.
- flash=1, sweep index 0..7 -> rgb=00 with transparent=1 at index 0, and rgb=3F at indices 1..7.
- Write wr_index=2, wr_rgb=03 while index=2 -> rgb=0C in the write cycle and 03 from the next cycle. Index 3 still reads 04.
- Assert wr_en (wr_index=4, wr_rgb=15) and reset in the same cycle -> after the edge, index 4 reads 3C.
- Write entry 0 with 2A, then set index=0 -> rgb=2A and transparent=1. With flash=1, rgb stays 2A.
- Overwrite entries 5, 6 and 7 on three consecutive cycles, then pulse reset -> all 8 entries read their defaults again.

Source files
------------

// File: rtl/koopa_palette_lut.sv
// Eight-entry Koopa sprite palette: 3-bit pixel index to 6-bit RRGGBB plus transparency.
// Combinational read path, run-time writable entries, flash-to-white for hit effects.
module koopa_palette_lut (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] index,
    output logic [5:0] rgb,
    output logic       transparent,
    input  logic       flash,
    input  logic       wr_en,
    input  logic [2:0] wr_index,
    input  logic [5:0] wr_rgb
);

    localparam logic [5:0] FLASH_WHITE = 6'h3F;

    logic [5:0] pal [8];

    function automatic logic [5:0] default_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    default_colour = 6'h00;
            3'd1:    default_colour = 6'h00;
            3'd2:    default_colour = 6'h0C;
            3'd3:    default_colour = 6'h04;
            3'd4:    default_colour = 6'h3C;
            3'd5:    default_colour = 6'h3F;
            3'd6:    default_colour = 6'h30;
            default: default_colour = 6'h38;
        endcase
    endfunction

    // NOTE: the palette lives in flops rather than RAM so every entry can be reloaded
    // by reset; a RAM macro cannot be cleared in one cycle and would leave X on rgb.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
                pal[i] <= default_colour(3'(i));
            end
        end else if (wr_en) begin
            pal[wr_index] <= wr_rgb;
        end
    end

    // Index 0 is the transparency key: its stored colour passes through even under flash.
    always_comb begin
        // NOTE: assigning defaults first guarantees no latch is inferred on any path.
        transparent = (index == 3'd0);
        rgb         = pal[index];
        if (!transparent && flash) begin
            rgb = FLASH_WHITE;
        end
    end

endmodule

// File: tb/tb_koopa_palette_lut.sv
// Directed self-checking bench for koopa_palette_lut: defaults, flash, writes, reset priority.
module tb_koopa_palette_lut;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] index;
    logic [5:0] rgb;
    logic       transparent;
    logic       flash;
    logic       wr_en;
    logic [2:0] wr_index;
    logic [5:0] wr_rgb;

    int errors = 0;
    int checks = 0;

    logic [5:0] defaults [8] = '{6'h00, 6'h00, 6'h0C, 6'h04, 6'h3C, 6'h3F, 6'h30, 6'h38};

    koopa_palette_lut dut (
        .clk         (clk),
        .reset       (reset),
        .index       (index),
        .rgb         (rgb),
        .transparent (transparent),
        .flash       (flash),
        .wr_en       (wr_en),
        .wr_index    (wr_index),
        .wr_rgb      (wr_rgb)
    );

    always #5 clk = ~clk;

    // Move to just after the next rising edge; inputs change and settle well before the following edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep_defaults(input string tag);
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            index = 3'(i);
            #1;
            checks++;
            if (rgb !== defaults[i]) begin
                errors++;
                $display("FAIL %s rgb idx=%0d got=%h exp=%h", tag, i, rgb, defaults[i]);
            end
            checks++;
            if (transparent !== (i == 0)) begin
                errors++;
                $display("FAIL %s transparent idx=%0d got=%b exp=%b", tag, i, transparent, (i == 0));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flash = 1'b0; wr_en = 1'b0; wr_index = '0; wr_rgb = '0; index = '0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        sweep_defaults("reset_sweep");
    endtask

    task automatic test_flash();
        logic [5:0] exp;
        flash = 1'b1;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            index = 3'(i);
            #1;
            exp = (i == 0) ? 6'h00 : 6'h3F;
            checks++;
            if (rgb !== exp) begin
                errors++;
                $display("FAIL flash_rgb idx=%0d got=%h exp=%h", i, rgb, exp);
            end
            checks++;
            if (transparent !== (i == 0)) begin
                errors++;
                $display("FAIL flash_transparent idx=%0d got=%b exp=%b", i, transparent, (i == 0));
            end
        end
        flash = 1'b0;
    endtask

    task automatic test_write_same_cycle();
        next_cycle();
        index = 3'd2; wr_en = 1'b1; wr_index = 3'd2; wr_rgb = 6'h03;
        #1;
        checks++;
        if (rgb !== 6'h0C) begin
            errors++;
            $display("FAIL write_cycle_old got=%h exp=0c", rgb);
        end
        next_cycle();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rgb !== 6'h03) begin
            errors++;
            $display("FAIL write_visible_next got=%h exp=03", rgb);
        end
        index = 3'd3;
        #1;
        checks++;
        if (rgb !== 6'h04) begin
            errors++;
            $display("FAIL write_neighbour_hold got=%h exp=04", rgb);
        end
    endtask

    task automatic test_reset_vs_write();
        // Recolour entry 4 first so the reset restore is observable.
        next_cycle();
        wr_en = 1'b1; wr_index = 3'd4; wr_rgb = 6'h11; index = 3'd4;
        next_cycle();
        wr_en = 1'b1; wr_index = 3'd4; wr_rgb = 6'h15; reset = 1'b1;
        #1;
        checks++;
        if (rgb !== 6'h11) begin
            errors++;
            $display("FAIL reset_high_read_live got=%h exp=11", rgb);
        end
        next_cycle();
        wr_en = 1'b0; reset = 1'b0;
        #1;
        checks++;
        if (rgb !== 6'h3C) begin
            errors++;
            $display("FAIL reset_beats_write got=%h exp=3c", rgb);
        end
        index = 3'd2;
        #1;
        checks++;
        if (rgb !== 6'h0C) begin
            errors++;
            $display("FAIL reset_restores_entry2 got=%h exp=0c", rgb);
        end
    endtask

    task automatic test_entry0();
        next_cycle();
        wr_en = 1'b1; wr_index = 3'd0; wr_rgb = 6'h2A;
        next_cycle();
        wr_en = 1'b0; index = 3'd0;
        #1;
        checks++;
        if (rgb !== 6'h2A) begin
            errors++;
            $display("FAIL entry0_rgb got=%h exp=2a", rgb);
        end
        checks++;
        if (transparent !== 1'b1) begin
            errors++;
            $display("FAIL entry0_transparent got=%b exp=1", transparent);
        end
        flash = 1'b1;
        #1;
        checks++;
        if (rgb !== 6'h2A) begin
            errors++;
            $display("FAIL entry0_flash got=%h exp=2a", rgb);
        end
        index = 3'd1;
        #1;
        checks++;
        if (rgb !== 6'h3F || transparent !== 1'b0) begin
            errors++;
            $display("FAIL entry1_flash got=%h/%b exp=3f/0", rgb, transparent);
        end
        flash = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp [8];
        exp = '{6'h2A, 6'h09, 6'h0C, 6'h04, 6'h3C, 6'h01, 6'h02, 6'h03};
        next_cycle();
        wr_en = 1'b1; wr_index = 3'd5; wr_rgb = 6'h01;
        next_cycle();
        wr_index = 3'd6; wr_rgb = 6'h02;
        next_cycle();
        wr_index = 3'd7; wr_rgb = 6'h03;
        next_cycle();
        wr_index = 3'd1; wr_rgb = 6'h07;
        next_cycle();
        wr_index = 3'd1; wr_rgb = 6'h09;
        next_cycle();
        wr_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            index = 3'(i);
            #1;
            checks++;
            if (rgb !== exp[i]) begin
                errors++;
                $display("FAIL b2b_entry idx=%0d got=%h exp=%h", i, rgb, exp[i]);
            end
        end
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        sweep_defaults("post_reset_sweep");
    endtask

    initial begin
        test_reset();
        test_flash();
        test_write_same_cycle();
        test_reset_vs_write();
        test_entry0();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
